// File: rtl/debug_pkg.sv
// Shared types and helpers for the debug dump path: section order, FSM states
// and the byte budget of a full dump.
package debug_pkg;

    typedef enum logic [1:0] {
        SEC_PC,
        SEC_LATCH,
        SEC_REGS,
        SEC_MEM
    } sec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_FINISH
    } state_t;

    localparam int LEN_DEFAULT    = 32;
    localparam int BYTES_PER_WORD = LEN_DEFAULT / 8;

    function automatic int total_bytes(input int bpw, input int nb_latch,
                                       input int cant_regs, input int cant_mem);
        return bpw + nb_latch + bpw * cant_regs + bpw * cant_mem;
    endfunction

endpackage

// File: rtl/byte_serializer.sv
// Word shift register that presents one byte at a time, LSB first. A single-byte
// load reports last immediately so latch bytes reuse the same path.
module byte_serializer #(
    parameter int LEN      = 32,
    parameter int LEN_DATA = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [LEN-1:0]      i_word,
    input  logic                i_single,
    input  logic                i_advance,
    output logic [LEN_DATA-1:0] o_byte,
    output logic                o_last
);

    localparam int BPW = LEN / LEN_DATA;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

    logic [LEN-1:0] r_shift;
    logic [BCW-1:0] r_byte_cnt;
    logic           r_single;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_single   <= 1'b0;
        end else if (i_load) begin
            r_shift    <= i_word;
            r_byte_cnt <= '0;
            r_single   <= i_single;
        end else if (i_advance) begin
            r_shift    <= r_shift >> LEN_DATA;
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

    assign o_byte = r_shift[LEN_DATA-1:0];
    assign o_last = r_single || (r_byte_cnt == BCW'(BPW - 1));

endmodule

// File: rtl/debug_dump_sequencer.sv
// Owns the debug UART during a state dump: PC, latch snapshot, register file and
// data memory are streamed byte by byte while the recolector is walked in step.
module debug_dump_sequencer
    import debug_pkg::*;
#(
    parameter int LEN            = 32,
    parameter int NB_LATCH_BYTES = 52,
    parameter int CANT_REGS      = 32,
    parameter int CANT_MEM       = 16,
    parameter int LEN_DATA       = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [LEN-1:0]              pc,
    input  logic [NB_LATCH_BYTES*8-1:0] latches,
    input  logic [LEN-1:0]              recolector,
    input  logic                        tx_done,
    output logic                        tx_start,
    output logic [LEN_DATA-1:0]         uart_data_out,
    output logic                        restart_recolector,
    output logic                        send_regs_recolector,
    output logic                        enable_next_recolector,
    output logic                        busy,
    output logic                        done
);

    localparam int MAX_A     = (NB_LATCH_BYTES > CANT_REGS) ? NB_LATCH_BYTES : CANT_REGS;
    localparam int MAX_ITEMS = (MAX_A > CANT_MEM) ? MAX_A : CANT_MEM;
    localparam int IW        = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;

    localparam logic [IW-1:0] LAST_LATCH = IW'(NB_LATCH_BYTES - 1);
    localparam logic [IW-1:0] LAST_REG   = IW'(CANT_REGS - 1);
    localparam logic [IW-1:0] LAST_MEM   = IW'(CANT_MEM - 1);

    state_t          r_state, w_state_nxt;
    sec_t            r_sec, w_sec_nxt;
    logic [IW-1:0]   r_item, w_item_nxt;

    logic [LEN-1:0]  r_pc_sh;
    logic [7:0]      r_latch_sh [NB_LATCH_BYTES];

    logic            w_accept;
    logic            w_load;
    logic            w_single;
    logic            w_advance;
    logic [LEN-1:0]  w_load_word;
    logic            w_ser_last;

    assign w_accept = (r_state == ST_IDLE) && start;

    // Shadow copies are pure data; they only matter once a dump is accepted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc_sh <= pc;
            for (int k = 0; k < NB_LATCH_BYTES; k++) begin
                r_latch_sh[k] <= latches[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sec   <= SEC_PC;
            r_item  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sec   <= w_sec_nxt;
            r_item  <= w_item_nxt;
        end
    end

    always_comb begin
        w_state_nxt            = r_state;
        w_sec_nxt              = r_sec;
        w_item_nxt             = r_item;
        w_load                 = 1'b0;
        w_single               = 1'b0;
        w_advance              = 1'b0;
        w_load_word            = '0;
        tx_start               = 1'b0;
        restart_recolector     = 1'b0;
        enable_next_recolector = 1'b0;
        done                   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                    w_sec_nxt   = SEC_PC;
                    w_item_nxt  = '0;
                end
            end
            ST_FETCH: begin
                restart_recolector     = (r_item == '0);
                enable_next_recolector = (r_item != '0);
                w_state_nxt            = ST_LOAD;
            end
            ST_LOAD: begin
                w_load = 1'b1;
                case (r_sec)
                    SEC_PC:    w_load_word = r_pc_sh;
                    SEC_LATCH: begin
                        w_load_word = {{(LEN-8){1'b0}}, r_latch_sh[r_item]};
                        w_single    = 1'b1;
                    end
                    default:   w_load_word = recolector;
                endcase
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                tx_start    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (!w_ser_last) begin
                        w_advance   = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else begin
                        case (r_sec)
                            SEC_PC: begin
                                w_state_nxt = ST_LOAD;
                                w_sec_nxt   = SEC_LATCH;
                                w_item_nxt  = '0;
                            end
                            SEC_LATCH: begin
                                if (r_item == LAST_LATCH) begin
                                    w_state_nxt = ST_FETCH;
                                    w_sec_nxt   = SEC_REGS;
                                    w_item_nxt  = '0;
                                end else begin
                                    w_state_nxt = ST_LOAD;
                                    w_item_nxt  = r_item + 1'b1;
                                end
                            end
                            SEC_REGS: begin
                                w_state_nxt = ST_FETCH;
                                if (r_item == LAST_REG) begin
                                    w_sec_nxt  = SEC_MEM;
                                    w_item_nxt = '0;
                                end else begin
                                    w_item_nxt = r_item + 1'b1;
                                end
                            end
                            default: begin
                                if (r_item == LAST_MEM) begin
                                    w_state_nxt = ST_FINISH;
                                end else begin
                                    w_state_nxt = ST_FETCH;
                                    w_item_nxt  = r_item + 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            ST_FINISH: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FINISH already counts as not busy so a new start lands right after done.
    assign busy                 = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign send_regs_recolector = busy && (r_sec == SEC_REGS);

    byte_serializer #(
        .LEN      (LEN),
        .LEN_DATA (LEN_DATA)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_word    (w_load_word),
        .i_single  (w_single),
        .i_advance (w_advance),
        .o_byte    (uart_data_out),
        .o_last    (w_ser_last)
    );

endmodule

// File: doc/debug_dump_sequencer.md
# debug_dump_sequencer

Sequencer that owns the debug UART transmitter during a state dump and schedules the MIPS debug sources onto it byte by byte. Sources, in order:
- PC
- pipeline latch snapshot
- 32 registers
- 16 data-memory words

It drives the recolector (restart / send_regs / enable_next) to walk registers and memory, and runs the UART tx_start/tx_done handshake. It sits between the debug state machine, which raises `start` when halted or after a step, and the uart/recolector blocks.

## Interface
Parameters:
- LEN, 32, datapath word width (bytes per word = LEN/8)
- NB_LATCH_BYTES, 52, total bytes of concatenated pipeline latches
- CANT_REGS, 32, register words dumped
- CANT_MEM, 16, data-memory words dumped
- LEN_DATA, 8, UART byte width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock (same domain as uart and recolector)
- reset  in  1  async active-high reset
- start  in  1  one-cycle request to begin a dump; ignored while busy
- pc  in  LEN  current PC
- latches  in  NB_LATCH_BYTES*8  flat latch bus, byte 0 = bits [7:0]
- recolector  in  LEN  word from recolector, valid 1 cycle after restart/enable_next
- tx_done  in  1  UART byte-sent pulse
- tx_start  out  1  one-cycle UART send pulse
- uart_data_out  out  LEN_DATA  byte to transmit
- restart_recolector  out  1  one-cycle pulse, recolector addr to 0
- send_regs_recolector  out  1  level: 1 = registers, 0 = memory
- enable_next_recolector  out  1  one-cycle pulse, recolector addr +1
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse at dump completion

## Operation
- Sections: SEC_PC, SEC_LATCH, SEC_REGS, SEC_MEM, always in that order. No section skipping.
- Total bytes: 4 + NB_LATCH_BYTES + 4*CANT_REGS + 4*CANT_MEM. With defaults this is 248.
- On accepted `start`, capture `pc` and `latches` into shadow registers. Later changes to these inputs do not affect the dump.
- Words are sent LSB byte first. Latch bytes are sent in index order 0..NB_LATCH_BYTES-1.
- FSM states:
  - IDLE
  - FETCH: issue restart/enable_next when a recolector word is needed
  - LOAD: load word or byte into tx shift register
  - SEND: tx_start=1
  - WAIT: hold until tx_done
  - FINISH: done=1
- Transitions:
  - IDLE→LOAD on start.
  - LOAD→SEND→WAIT.
  - WAIT→SEND (next byte of same word, shift right 8) or →FETCH (word needs recolector) or →LOAD (next shadow word/byte) or →FINISH (last byte).
  - FETCH→LOAD.
  - FINISH→IDLE.
- Recolector:
  - On entry to SEC_REGS, FETCH asserts restart_recolector with send_regs_recolector=1.
  - Subsequent register words assert enable_next_recolector in FETCH.
  - SEC_MEM does the same with send_regs_recolector=0.
  - send_regs_recolector holds its level for the whole section. It is 0 in IDLE.
- Counters: byte_cnt (0..LEN/8-1), item_cnt (sized for max(NB_LATCH_BYTES, CANT_REGS, CANT_MEM)). Both wrap to 0 on section change.
- uart_data_out is stable from the tx_start cycle until the tx_done cycle.
- tx_done outside WAIT is ignored. A start pulse while busy is ignored, with no queueing.
- Reset at any time, including mid-byte: state=IDLE and all outputs 0 immediately (async). There is no resume; a new `start` restarts from SEC_PC.

## Timing
- Reset values:
  - tx_start=0, uart_data_out=0
  - restart/enable_next/send_regs=0
  - busy=0, done=0
- start at cycle N: busy=1 at N+1 (LOAD), tx_start at N+2 for PC byte 0.
- Within a word: tx_done at M gives tx_start at M+1.
- Shadow boundary (PC→latch, latch→latch): tx_done at M gives LOAD at M+1 and tx_start at M+2.
- Recolector word: tx_done at M gives restart/enable_next at M+1, sample `recolector` at M+2 (LOAD), tx_start at M+3.
- Last byte tx_done at M: done=1 and busy=0 at M+1. A new start is accepted at M+2.
- Simultaneous start and tx_done in IDLE: start accepted, tx_done ignored.

## Structure
- Shared package `debug_pkg`:
  - section enum (SEC_PC..SEC_MEM)
  - FSM state enum
  - BYTES_PER_WORD = LEN/8
  - total-byte-count function
- One sub-module is natural: `byte_serializer`, a word shift register plus byte counter emitting LSB-first bytes on `advance`. The FSM and section/item counters stay in the top.

## Test plan
- Reset mid-dump (assert reset while WAIT on byte 100) → all outputs 0 same cycle. After release plus start, first byte is PC[7:0].
- pc=32'h0000_0040, latches byte k = k, start → bytes 40,00,00,00, then 00,01,…,33 (hex), in order.
- Recolector model returns 32'hA0+i for reg i and 32'h500+j for mem j → reg0 bytes A0,00,00,00. Exactly 1 restart and 31 enable_next with send_regs=1, then 1 restart and 15 enable_next with send_regs=0.
- UART model with tx_done fixed 10 cycles after tx_start → exactly 248 tx_start pulses, done pulse once, busy low afterwards.
- start pulsed again mid-dump and pc changed mid-dump → no restart, PC bytes equal the captured value.
- tx_done injected in IDLE and in SEND → no state change, no extra tx_start.
